// File: rtl/swizzle_c2d_sequencer_if.sv
// Bus bundle between the CRAM-to-DRAM unload sequencer, the compute-RAM read
// port and the swizzle_cram_to_dram input side.
//   ram_addr/ram_re    : CRAM read request (data returns one cycle later)
//   ram_rdata          : CRAM read data
//   sw_data_valid/sw_data/sw_data_last : word stream into the swizzle
//   sw_addr_start/sw_dma_mode          : per-job swizzle configuration
//   sw_mem_we          : swizzle write-back strobe
// master = sequencer side, slave = RAM/swizzle side.
interface swizzle_c2d_sequencer_if #(
  parameter int RAM_DWIDTH = 40,
  parameter int RAM_AWIDTH = 9,
  parameter int MEM_AWIDTH = 16
);
  logic [RAM_AWIDTH-1:0] ram_addr;
  logic                  ram_re;
  logic [RAM_DWIDTH-1:0] ram_rdata;
  logic                  sw_data_valid;
  logic [RAM_DWIDTH-1:0] sw_data;
  logic                  sw_data_last;
  logic [MEM_AWIDTH-1:0] sw_addr_start;
  logic                  sw_dma_mode;
  logic                  sw_mem_we;

  modport master (
    output ram_addr, ram_re, sw_data_valid, sw_data, sw_data_last,
           sw_addr_start, sw_dma_mode,
    input  ram_rdata, sw_mem_we
  );

  modport slave (
    input  ram_addr, ram_re, sw_data_valid, sw_data, sw_data_last,
           sw_addr_start, sw_dma_mode,
    output ram_rdata, sw_mem_we
  );
endinterface

// File: rtl/swizzle_c2d_sequencer.sv
// Sequences one CRAM-to-DRAM unload: on an accepted start it reads
// cfg_num_words consecutive CRAM words, streams them into the swizzle with
// valid/last, counts swizzle write-back strobes and then pulses done.
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   start            : 1-cycle request, honoured only when idle
//   cfg_ram_base     : first CRAM word address
//   cfg_num_words    : number of words (0 allowed)
//   cfg_mem_base     : DRAM start address handed to the swizzle
//   cfg_dma_mode     : swizzle dma_mode
//   busy, done, err  : status (err is sticky until the next accepted start)
//   bus              : CRAM read port and swizzle input (master side)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start
// S_READ   | one CRAM read per cycle, addresses base..base+n-1
// S_DRAIN  | no read; final word is on the swizzle input this cycle
// S_WAIT_WB| waiting for n write-back strobes or the timeout
// S_DONE   | done pulse, then back to idle
module swizzle_c2d_sequencer #(
  parameter int RAM_DWIDTH = 40,
  parameter int RAM_AWIDTH = 9,
  parameter int MEM_AWIDTH = 16,
  parameter int CNT_WIDTH  = 10,
  parameter int WB_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [RAM_AWIDTH-1:0] cfg_ram_base,
  input  logic [CNT_WIDTH-1:0]  cfg_num_words,
  input  logic [MEM_AWIDTH-1:0] cfg_mem_base,
  input  logic                  cfg_dma_mode,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  swizzle_c2d_sequencer_if.master bus
);

  localparam int TMR_W = $clog2(WB_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WAIT_WB,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [RAM_AWIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  rd_cnt_q;
  logic [CNT_WIDTH-1:0]  we_cnt_q;
  logic [TMR_W-1:0]      timer_q;
  logic [MEM_AWIDTH-1:0] mem_base_q;
  logic                  dma_q;
  logic                  err_q;
  logic                  valid_q;
  logic                  last_q;

  logic accept;
  logic last_rd;
  logic set_err;

  assign accept  = (state_q == S_IDLE) && start;
  assign last_rd = (state_q == S_READ) && (rd_cnt_q == num_q - CNT_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (cfg_num_words == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WAIT_WB;
      S_WAIT_WB: begin
        if (we_cnt_q == num_q) begin
          state_d = S_DONE;
        end else if (timer_q == TMR_W'(WB_TIMEOUT)) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      num_q      <= '0;
      rd_cnt_q   <= '0;
      we_cnt_q   <= '0;
      timer_q    <= '0;
      mem_base_q <= '0;
      dma_q      <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Read data arrives one cycle after the request, so valid/last trail it.
      valid_q <= (state_q == S_READ);
      last_q  <= last_rd;

      if (state_q == S_WAIT_WB) timer_q <= timer_q + TMR_W'(1);
      else                      timer_q <= '0;

      if (accept) begin
        addr_q     <= cfg_ram_base;
        num_q      <= cfg_num_words;
        mem_base_q <= cfg_mem_base;
        dma_q      <= cfg_dma_mode;
        rd_cnt_q   <= '0;
        we_cnt_q   <= '0;
        err_q      <= 1'b0;
      end else begin
        if (state_q == S_READ) begin
          addr_q   <= addr_q + RAM_AWIDTH'(1);  // wraps around the CRAM
          rd_cnt_q <= rd_cnt_q + CNT_WIDTH'(1);
        end
        // Strobes are counted in every busy state and saturate at n.
        if (state_q != S_IDLE && bus.sw_mem_we && we_cnt_q != num_q) begin
          we_cnt_q <= we_cnt_q + CNT_WIDTH'(1);
        end
        if (set_err) err_q <= 1'b1;
      end
    end
  end

  assign busy = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_WAIT_WB);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  assign bus.ram_addr      = addr_q;
  assign bus.ram_re        = (state_q == S_READ);
  assign bus.sw_data_valid = valid_q;
  assign bus.sw_data       = bus.ram_rdata;
  assign bus.sw_data_last  = last_q;
  assign bus.sw_addr_start = mem_base_q;
  assign bus.sw_dma_mode   = dma_q;

endmodule

// File: tb/tb_swizzle_c2d_sequencer.sv
module tb_swizzle_c2d_sequencer;
  localparam int RAM_DWIDTH = 40;
  localparam int RAM_AWIDTH = 9;
  localparam int MEM_AWIDTH = 16;
  localparam int CNT_WIDTH  = 10;
  localparam int WB_TIMEOUT = 1023;

  typedef struct {
    logic [RAM_DWIDTH-1:0] data;
    logic                  last;
  } exp_t;

  logic                  clk;
  logic                  resetn;
  logic                  start;
  logic [RAM_AWIDTH-1:0] cfg_ram_base;
  logic [CNT_WIDTH-1:0]  cfg_num_words;
  logic [MEM_AWIDTH-1:0] cfg_mem_base;
  logic                  cfg_dma_mode;
  logic                  busy;
  logic                  done;
  logic                  err;

  swizzle_c2d_sequencer_if #(
    .RAM_DWIDTH(RAM_DWIDTH), .RAM_AWIDTH(RAM_AWIDTH), .MEM_AWIDTH(MEM_AWIDTH)
  ) bus ();

  swizzle_c2d_sequencer #(
    .RAM_DWIDTH(RAM_DWIDTH), .RAM_AWIDTH(RAM_AWIDTH), .MEM_AWIDTH(MEM_AWIDTH),
    .CNT_WIDTH(CNT_WIDTH), .WB_TIMEOUT(WB_TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_ram_base(cfg_ram_base), .cfg_num_words(cfg_num_words),
    .cfg_mem_base(cfg_mem_base), .cfg_dma_mode(cfg_dma_mode),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [RAM_DWIDTH-1:0] mem [1 << RAM_AWIDTH];
  logic [RAM_AWIDTH-1:0] addr_q [$];
  exp_t                  data_q [$];
  logic [MEM_AWIDTH-1:0] exp_mem_base;
  logic                  exp_dma;
  int tick = 0;
  int re_count, re_first, re_last, vcount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CRAM model: registered read, data one cycle after ram_re.
  always @(posedge clk) begin
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the expected read address / stream word whenever the DUT presents one.
  always @(negedge clk) begin
    logic [RAM_AWIDTH-1:0] ea;
    exp_t ed;
    tick++;
    if (resetn && bus.ram_re) begin
      re_count++;
      if (re_count == 1) re_first = tick;
      re_last = tick;
      if (addr_q.size() == 0) begin
        chk(1'b0, "unexpected_read", 64'(bus.ram_addr), 64'(0));
      end else begin
        ea = addr_q.pop_front();
        chk(bus.ram_addr == ea, "ram_addr", 64'(bus.ram_addr), 64'(ea));
      end
    end
    if (resetn && bus.sw_data_valid) begin
      vcount++;
      if (data_q.size() == 0) begin
        chk(1'b0, "unexpected_valid", 64'(bus.sw_data), 64'(0));
      end else begin
        ed = data_q.pop_front();
        chk(bus.sw_data == ed.data, "sw_data", 64'(bus.sw_data), 64'(ed.data));
        chk(bus.sw_data_last == ed.last, "sw_data_last", 64'(bus.sw_data_last), 64'(ed.last));
        chk(bus.sw_addr_start == exp_mem_base, "sw_addr_start", 64'(bus.sw_addr_start), 64'(exp_mem_base));
        chk(bus.sw_dma_mode == exp_dma, "sw_dma_mode", 64'(bus.sw_dma_mode), 64'(exp_dma));
      end
    end
  end

  task automatic randomize_cfg();
    cfg_ram_base  = RAM_AWIDTH'($urandom);
    cfg_num_words = CNT_WIDTH'($urandom_range(1, 200));
    cfg_mem_base  = MEM_AWIDTH'($urandom);
    cfg_dma_mode  = 1'($urandom);
  endtask

  task automatic check_zero(input string tag);
    chk(busy == 1'b0, {tag, "_busy"}, 64'(busy), 64'(0));
    chk(done == 1'b0, {tag, "_done"}, 64'(done), 64'(0));
    chk(err == 1'b0, {tag, "_err"}, 64'(err), 64'(0));
    chk(bus.ram_re == 1'b0, {tag, "_ram_re"}, 64'(bus.ram_re), 64'(0));
    chk(bus.ram_addr == '0, {tag, "_ram_addr"}, 64'(bus.ram_addr), 64'(0));
    chk(bus.sw_data_valid == 1'b0, {tag, "_valid"}, 64'(bus.sw_data_valid), 64'(0));
    chk(bus.sw_data_last == 1'b0, {tag, "_last"}, 64'(bus.sw_data_last), 64'(0));
    chk(bus.sw_addr_start == '0, {tag, "_addr_start"}, 64'(bus.sw_addr_start), 64'(0));
    chk(bus.sw_dma_mode == 1'b0, {tag, "_dma"}, 64'(bus.sw_dma_mode), 64'(0));
  endtask

  // One job: push the expected read/stream sequence, start, emulate the swizzle's
  // write-back strobes (n_we of them), optionally re-pulse start or reset mid-job.
  task automatic run_job(input logic [RAM_AWIDTH-1:0] base, input int n,
                         input logic [MEM_AWIDTH-1:0] mbase, input logic dma,
                         input int n_we, input int restart_at, input int reset_at);
    int cyc, done_cnt, done_cyc, strobes, limit;
    logic [RAM_AWIDTH-1:0] a;
    bit exp_err;
    exp_t e;
    exp_err = (n_we < n);
    for (int i = 0; i < n; i++) begin
      a = base + RAM_AWIDTH'(i);
      addr_q.push_back(a);
      e.data = mem[a];
      e.last = (i == n - 1);
      data_q.push_back(e);
    end
    exp_mem_base = mbase;
    exp_dma      = dma;
    re_count = 0;
    vcount   = 0;

    @(posedge clk); #1;
    start         = 1'b1;
    cfg_ram_base  = base;
    cfg_num_words = CNT_WIDTH'(n);
    cfg_mem_base  = mbase;
    cfg_dma_mode  = dma;
    @(posedge clk); #1;
    start = 1'b0;
    randomize_cfg();
    chk(busy == (n != 0), "busy_after_start", 64'(busy), 64'(n != 0));
    chk(err == 1'b0, "err_cleared_on_start", 64'(err), 64'(0));

    strobes  = n_we;
    done_cnt = 0;
    done_cyc = -1;
    cyc      = 0;
    limit    = n + WB_TIMEOUT + 40;
    while (cyc < limit && !(done_cnt > 0 && cyc > done_cyc + 2)) begin
      if (cyc == reset_at) begin
        sw_mem_we_drive(1'b0);
        start  = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check_zero("after_reset");
        addr_q.delete();
        data_q.delete();
        return;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
        chk(busy == 1'b0, "busy_low_at_done", 64'(busy), 64'(0));
        chk(err == exp_err, "err_at_done", 64'(err), 64'(exp_err));
      end
      start = (cyc == restart_at);
      if (start) randomize_cfg();
      sw_mem_we_drive(1'b0);
      if (busy && strobes > 0 && $urandom_range(0, 1) == 1) begin
        sw_mem_we_drive(1'b1);
        strobes--;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    sw_mem_we_drive(1'b0);
    chk(done_cnt == 1, "done_count", 64'(done_cnt), 64'(1));
    chk(addr_q.size() == 0, "reads_missing", 64'(addr_q.size()), 64'(0));
    chk(data_q.size() == 0, "words_missing", 64'(data_q.size()), 64'(0));
    chk(re_count == n, "read_count", 64'(re_count), 64'(n));
    chk(vcount == n, "valid_count", 64'(vcount), 64'(n));
    if (n > 0) chk(re_last - re_first == n - 1, "read_burst_contiguous", 64'(re_last - re_first), 64'(n - 1));
    else       chk(done_cyc == 0, "zero_len_done_latency", 64'(done_cyc), 64'(0));
    chk(err == exp_err, "err_sticky_after_done", 64'(err), 64'(exp_err));
    addr_q.delete();
    data_q.delete();
  endtask

  task automatic sw_mem_we_drive(input logic v);
    bus.sw_mem_we = v;
  endtask

  initial begin
    int n;
    for (int i = 0; i < (1 << RAM_AWIDTH); i++) mem[i] = RAM_DWIDTH'({$urandom(), $urandom()});
    resetn        = 1'b0;
    start         = 1'b0;
    bus.sw_mem_we = 1'b0;
    randomize_cfg();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    resetn = 1'b1;

    run_job(9'h000, 80, 16'h0100, 1'b1, 80, -1, -1);
    run_job(RAM_AWIDTH'($urandom), 0, MEM_AWIDTH'($urandom), 1'b0, 0, -1, -1);
    run_job(9'h1F0, 32, MEM_AWIDTH'($urandom), 1'($urandom), 32, -1, -1);
    run_job(RAM_AWIDTH'($urandom), 30, MEM_AWIDTH'($urandom), 1'b1, 30, 5, -1);
    run_job(RAM_AWIDTH'($urandom), 40, MEM_AWIDTH'($urandom), 1'b0, 10, -1, -1);
    run_job(RAM_AWIDTH'($urandom), 20, MEM_AWIDTH'($urandom), 1'b1, 20, -1, -1);
    run_job(RAM_AWIDTH'($urandom), 50, MEM_AWIDTH'($urandom), 1'b1, 50, -1, 10);
    run_job(RAM_AWIDTH'($urandom), 25, MEM_AWIDTH'($urandom), 1'b0, 25, -1, -1);
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 100);
      run_job(RAM_AWIDTH'($urandom), n, MEM_AWIDTH'($urandom), 1'($urandom),
              n + int'($urandom_range(0, 3)), -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
